// File: rtl/fb_arb_pkg.sv
// Shared constants, state encoding and colour palette for the framebuffer
// write arbiter and the pixel producers that feed it.
package fb_arb_pkg;

    localparam int FB_ADDR_W        = 15;
    localparam int FB_DATA_W        = 24;
    localparam int FB_DEPTH_DEFAULT = 14400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic [FB_DATA_W-1:0] WHITE = 24'hFFFFFF;
    localparam logic [FB_DATA_W-1:0] P1    = 24'h98F5F9;
    localparam logic [FB_DATA_W-1:0] P2    = 24'hFE5C5E;
    localparam logic [FB_DATA_W-1:0] P1K   = 24'h3F97FC;
    localparam logic [FB_DATA_W-1:0] P2K   = 24'hD80305;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin chooser: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx
);

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    logic found;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[IDX_W'(wrap_idx(int'(ptr) + k))]) begin
                found = 1'b1;
                win_idx = IDX_W'(wrap_idx(int'(ptr) + k));
                win_onehot[IDX_W'(wrap_idx(int'(ptr) + k))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the single framebuffer write port; each grant writes
// one pixel for WR_HOLD cycles, or is rejected when the address is off-screen.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int WR_HOLD  = 3,
    parameter int FB_DEPTH = FB_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*FB_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*FB_DATA_W-1:0]   req_data,
    input  logic                           freeze,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           err,
    output logic [FB_ADDR_W-1:0]           fb_addr,
    output logic [FB_DATA_W-1:0]           fb_data,
    output logic                           fb_we,
    output logic                           busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(WR_HOLD + 2);
    localparam logic [FB_ADDR_W:0] DEPTH_LIM = (FB_ADDR_W + 1)'(FB_DEPTH);
    // A rejected request waits this many extra cycles in RELEASE before done/err.
    localparam logic [CNT_W-1:0] REJ_WAIT = CNT_W'(1);

    logic [FB_ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [FB_DATA_W-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*FB_ADDR_W +: FB_ADDR_W];
            assign data_arr[gi] = req_data[gi*FB_DATA_W +: FB_DATA_W];
        end
    endgenerate

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [FB_DATA_W-1:0] fb_data_q, fb_data_d;
    logic                 fb_we_q, fb_we_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     win_idx_q, win_idx_d;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic [FB_ADDR_W-1:0] sel_addr;
    logic [FB_DATA_W-1:0] sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (rr_ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // One-hot AND-OR mux avoids indexing past NUM_REQ with a wider index.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_addr = sel_addr | addr_arr[i];
                sel_data = sel_data | data_arr[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        fb_we_d   = fb_we_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        win_idx_d = win_idx_q;

        unique case (state_q)
            IDLE: begin
                if (!freeze && (req != '0)) begin
                    grant_d   = win_onehot;
                    busy_d    = 1'b1;
                    fb_addr_d = sel_addr;
                    fb_data_d = sel_data;
                    win_idx_d = win_idx;
                    cnt_d     = '0;
                    if ({1'b0, sel_addr} < DEPTH_LIM) begin
                        fb_we_d = 1'b1;
                        state_d = WRITE;
                    end else begin
                        fb_we_d = 1'b0;
                        state_d = RELEASE;
                    end
                end
            end

            WRITE: begin
                if (cnt_q == CNT_W'(WR_HOLD - 1)) begin
                    fb_we_d = 1'b0;
                    done_d  = grant_q;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (done_q != '0) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    rr_ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ?
                               '0 : win_idx_q + IDX_W'(1);
                    state_d  = IDLE;
                end else if (cnt_q == REJ_WAIT) begin
                    done_d = grant_q;
                    err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                fb_we_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            win_idx_q <= win_idx_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign fb_we   = fb_we_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a vector table of single transactions
// followed by hand-written fairness, freeze, input-change and reset sequences.
module tb_fb_write_arbiter;
    import fb_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int WR_HOLD = 3;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_REQ-1:0]           req = '0;
    logic [NUM_REQ*FB_ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*FB_DATA_W-1:0] req_data = '0;
    logic                         freeze = 1'b0;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic                         err;
    logic [FB_ADDR_W-1:0]         fb_addr;
    logic [FB_DATA_W-1:0]         fb_data;
    logic                         fb_we;
    logic                         busy;

    fb_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WR_HOLD  (WR_HOLD),
        .FB_DEPTH (14400)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .freeze   (freeze),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [14:0] a0, a1, a2;
        logic [23:0] d0, d1, d2;
        logic [2:0]  exp_grant;
        logic [14:0] exp_addr;
        logic [23:0] exp_data;
        logic        exp_rej;
    } vec_t;

    vec_t vecs [6];

    task automatic set_inputs(input vec_t v);
        req      = v.req;
        req_addr = {v.a2, v.a1, v.a0};
        req_data = {v.d2, v.d1, v.d0};
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, 64'(n < 30), 64'd1);
    endtask

    // Runs one granted transaction from the negedge where inputs were driven.
    task automatic run_vec(input int idx, input vec_t v);
        set_inputs(v);
        @(negedge clk);
        chk($sformatf("v%0d_grant", idx), 64'(grant), 64'(v.exp_grant));
        chk($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
        chk($sformatf("v%0d_addr", idx), 64'(fb_addr), 64'(v.exp_addr));
        chk($sformatf("v%0d_data", idx), 64'(fb_data), 64'(v.exp_data));
        req = '0;
        if (!v.exp_rej) begin
            chk($sformatf("v%0d_we1", idx), 64'(fb_we), 64'd1);
            repeat (WR_HOLD - 1) @(negedge clk);
            chk($sformatf("v%0d_we_last", idx), 64'({fb_we, done}), 64'({1'b1, 3'b000}));
            @(negedge clk);
            chk($sformatf("v%0d_done", idx), 64'({fb_we, done, err}), 64'({1'b0, v.exp_grant, 1'b0}));
        end else begin
            chk($sformatf("v%0d_we_rej", idx), 64'({fb_we, done}), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_rej_wait", idx), 64'({fb_we, done, err}), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_err", idx), 64'({fb_we, done, err}), 64'({1'b0, v.exp_grant, 1'b1}));
        end
        @(negedge clk);
        chk($sformatf("v%0d_release", idx), 64'({grant, done, err, busy}), 64'd0);
        $display("txn v%0d req=%b grant=%b addr=%0d rej=%0d", idx, v.req, v.exp_grant, v.exp_addr, v.exp_rej);
    endtask

    int grant_time [4];
    logic [2:0] grant_val [4];

    initial begin
        // rr_ptr walks 0 -> 1 -> 2 -> 0 -> 2 -> 1 -> 0 across these vectors.
        vecs[0] = '{3'b001, 15'd100, 15'd0, 15'd0, WHITE, 24'd0, 24'd0, 3'b001, 15'd100, WHITE, 1'b0};
        vecs[1] = '{3'b010, 15'd0, 15'd14400, 15'd0, 24'd0, P2, 24'd0, 3'b010, 15'd14400, P2, 1'b1};
        vecs[2] = '{3'b111, 15'd1, 15'd2, 15'd14399, P1, P1K, P2, 3'b100, 15'd14399, P2, 1'b0};
        vecs[3] = '{3'b110, 15'd3, 15'd7, 15'd8, P2K, P1, WHITE, 3'b010, 15'd7, P1, 1'b0};
        vecs[4] = '{3'b011, 15'd0, 15'd11, 15'd12, P1K, P2K, P1, 3'b001, 15'd0, P1K, 1'b0};
        vecs[5] = '{3'b101, 15'd20, 15'd21, 15'd32767, P1, P2, P2K, 3'b100, 15'd32767, P2K, 1'b1};

        #1;
        chk("reset_outputs", 64'({grant, done, err, fb_we, busy}), 64'd0);
        chk("reset_fb", 64'({fb_addr, fb_data}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Fairness: all three held high, grants must rotate 5 cycles apart.
        req_addr = {15'd300, 15'd200, 15'd100};
        req_data = {P2, P1, WHITE};
        req = 3'b111;
        begin
            int n = 0;
            int seen = 0;
            logic [2:0] prev = '0;
            while (seen < 4 && n < 40) begin
                @(negedge clk);
                n++;
                if (grant != '0 && prev == '0) begin
                    grant_time[seen] = n;
                    grant_val[seen] = grant;
                    seen++;
                    if (seen == 4) req = '0;
                end
                prev = grant;
            end
            chk("fair_count", 64'(seen), 64'd4);
            chk("fair_order", 64'({grant_val[0], grant_val[1], grant_val[2], grant_val[3]}),
                64'({3'b001, 3'b010, 3'b100, 3'b001}));
            for (int k = 1; k < 4; k++)
                chk($sformatf("fair_gap%0d", k), 64'(grant_time[k] - grant_time[k-1]), 64'(WR_HOLD + 2));
            $display("txn fairness order=%b,%b,%b,%b", grant_val[0], grant_val[1], grant_val[2], grant_val[3]);
        end
        req = '0;
        wait_idle("fair");

        // Freeze blocks grants, then a mid-WRITE freeze must not shorten fb_we.
        freeze = 1'b1;
        req_addr = {15'd0, 15'd0, 15'd42};
        req_data = {24'd0, 24'd0, P1};
        req = 3'b001;
        begin
            logic any_grant = 1'b0;
            int we_cycles = 0;
            repeat (20) begin
                @(negedge clk);
                if (grant != '0 || busy) any_grant = 1'b1;
            end
            chk("freeze_blocks", 64'(any_grant), 64'd0);
            freeze = 1'b0;
            @(negedge clk);
            chk("unfreeze_grant", 64'(grant), 64'b001);
            freeze = 1'b1;
            req = '0;
            while (fb_we && we_cycles < 10) begin
                we_cycles++;
                @(negedge clk);
            end
            chk("freeze_we_len", 64'(we_cycles), 64'(WR_HOLD));
            chk("freeze_done", 64'(done), 64'b001);
            $display("txn freeze we_cycles=%0d", we_cycles);
        end
        wait_idle("freeze");
        freeze = 1'b0;

        // Address change after the grant edge must be ignored.
        req_addr = {15'd0, 15'd0, 15'd5};
        req = 3'b001;
        @(negedge clk);
        chk("chg_grant", 64'(grant), 64'b001);
        req_addr = {15'd0, 15'd0, 15'd9};
        req = '0;
        begin
            logic stable = 1'b1;
            repeat (WR_HOLD - 1) begin
                @(negedge clk);
                if (fb_addr != 15'd5 || !fb_we) stable = 1'b0;
            end
            chk("chg_addr_held", 64'(stable), 64'd1);
            @(negedge clk);
            chk("chg_done", 64'(done), 64'b001);
            $display("txn input-change fb_addr=%0d", fb_addr);
        end
        wait_idle("chg");

        // Reset on the second fb_we cycle clears outputs without a clock edge.
        req_addr = {15'd77, 15'd0, 15'd6};
        req = 3'b001;
        @(negedge clk);
        chk("rstw_grant", 64'(grant), 64'b001);
        @(negedge clk);
        chk("rstw_we2", 64'(fb_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstw_async", 64'({fb_we, grant, busy}), 64'd0);
        req = 3'b100;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_regrant", 64'(grant), 64'b100);
        chk("rstw_addr", 64'(fb_addr), 64'd77);
        req = '0;
        $display("txn reset-mid-write regrant=%b", grant);
        wait_idle("rstw");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
